// File: rtl/spi_sequencer_if.sv
// Request and read-result bundle between a register client and spi_sequencer.
// The master drives requests; the slave (the sequencer) answers with read bytes and status.
interface spi_sequencer_if;
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [7:0] req_addr;
   logic [7:0] req_wdata;
   logic [2:0] req_len;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_last;
   logic       done;
   logic       err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_len,
      input  req_ready, rd_data, rd_valid, rd_last, done, err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_len,
      output req_ready, rd_data, rd_valid, rd_last, done, err
   );
endinterface

// File: rtl/spi_sequencer.sv
// SPI register-access sequencer: frames command/address/data bytes into a TX FIFO
// under chip select, pops the echoed RX bytes and returns read data.
module spi_sequencer #(
   parameter int CS_SETUP = 2,
   parameter int CS_GAP   = 4,
   parameter int TIMEOUT  = 1023
) (
   input  logic       clk,
   input  logic       rst,
   spi_sequencer_if.slave bus,
   output logic       tx_write,
   output logic [7:0] tx_data,
   input  logic       tx_full,
   output logic       rx_read,
   input  logic [7:0] rx_data,
   input  logic       rx_empty,
   output logic       cs_n
);

   typedef enum logic [2:0] {
      IDLE, SETUP, XFER, GAP, ABORT
   } state_t;

   state_t      state, state_nx;
   logic        alive, aborted, is_wr;
   logic [7:0]  addr, wdata;
   logic [2:0]  len;
   logic [3:0]  n, tx_cnt, rx_cnt;
   logic [7:0]  wait_cnt;
   logic [15:0] idle_cnt;
   logic [7:0]  rd_data;
   logic        rd_valid, rd_last;
   logic        accept, fin, timeout, pop, rd_hit;

   assign n      = is_wr ? 4'd3 : {1'b0, len} + 4'd3;
   assign accept = bus.req_valid && bus.req_ready;
   assign cs_n   = !(state == SETUP || state == XFER);
   assign fin    = state == XFER && rx_cnt == n;
   assign pop    = rx_read && state == XFER;
   assign rd_hit = pop && !is_wr && rx_cnt >= 4'd2;

   // Idle counter reaches TIMEOUT on the edge that enters ABORT.
   assign timeout = state == XFER && !fin && !rx_read &&
                    idle_cnt == 16'(TIMEOUT - 1);

   // Ready is held off until the first edge after reset release.
   assign bus.req_ready = alive && state == IDLE;
   assign bus.rd_data   = rd_data;
   assign bus.rd_valid  = rd_valid;
   assign bus.rd_last   = rd_last;
   assign bus.done      = fin;
   assign bus.err       = state == ABORT;

   always_comb begin
      tx_write = state == XFER && tx_cnt < n && !tx_full;
      rx_read  = !rx_empty &&
                 ((state == XFER && rx_cnt < n) ||
                  (state == GAP && aborted));
   end

   always_comb begin
      tx_data = 8'h00;
      if (tx_write) begin
         unique case (1'b1)
            (tx_cnt == 4'd0): tx_data = is_wr ? 8'h0A : 8'h0B;
            (tx_cnt == 4'd1): tx_data = addr;
            (tx_cnt == 4'd2): tx_data = is_wr ? wdata : 8'h00;
            default:          tx_data = 8'h00;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (accept) state_nx = SETUP;
         SETUP: if (wait_cnt == 8'(CS_SETUP - 1)) state_nx = XFER;
         XFER: begin
            if (fin)          state_nx = GAP;
            else if (timeout) state_nx = ABORT;
         end
         ABORT: state_nx = GAP;
         GAP:   if (wait_cnt == 8'(CS_GAP - 1)) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         alive    <= 1'b0;
         aborted  <= 1'b0;
         is_wr    <= 1'b0;
         addr     <= 8'h00;
         wdata    <= 8'h00;
         len      <= 3'd0;
         tx_cnt   <= 4'd0;
         rx_cnt   <= 4'd0;
         wait_cnt <= 8'd0;
         idle_cnt <= 16'd0;
         rd_data  <= 8'h00;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
      end else begin
         state <= state_nx;
         alive <= 1'b1;
         if (state_nx == state && (state == SETUP || state == GAP))
            wait_cnt <= wait_cnt + 8'd1;
         else
            wait_cnt <= 8'd0;
         if (accept) begin
            is_wr   <= bus.req_write;
            addr    <= bus.req_addr;
            wdata   <= bus.req_wdata;
            len     <= bus.req_len;
            aborted <= 1'b0;
            tx_cnt  <= 4'd0;
            rx_cnt  <= 4'd0;
         end else begin
            if (tx_write) tx_cnt <= tx_cnt + 4'd1;
            if (pop)      rx_cnt <= rx_cnt + 4'd1;
         end
         if (state == ABORT) aborted <= 1'b1;
         if (state != XFER || pop)
            idle_cnt <= 16'd0;
         else
            idle_cnt <= idle_cnt + 16'd1;
         rd_valid <= rd_hit;
         rd_last  <= rd_hit && rx_cnt == n - 4'd1;
         if (rd_hit) rd_data <= rx_data;
      end
   end

endmodule

// File: tb/tb_spi_sequencer.sv
// Directed bench for spi_sequencer with an echoing SPI/FIFO model.
// Each task drives one scenario and checks against hand-computed values.
module tb_spi_sequencer;
   localparam int CS_SETUP = 2;
   localparam int CS_GAP   = 4;
   localparam int TIMEOUT  = 1023;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tx_write, rx_read, cs_n;
   logic [7:0] tx_data;
   logic       tx_full = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_empty = 1'b1;

   spi_sequencer_if bus ();

   spi_sequencer #(
      .CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .tx_write(tx_write), .tx_data(tx_data), .tx_full(tx_full),
      .rx_read(rx_read), .rx_data(rx_data), .rx_empty(rx_empty),
      .cs_n(cs_n)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   logic [7:0] rxq[$];
   logic [7:0] miso[$];
   logic [7:0] tx_log[$];
   logic [8:0] rd_log[$];
   bit rx_hold = 0, bp_en = 0, cur_write = 0;
   int pushes = 0, full_cnt = 0;
   int cyc = 0, first_tx = -1, done_cnt = 0, err_cnt = 0;
   int done_cyc = -1, err_cyc = -1, csfall_cyc = -1, rdy_rise_cyc = -1;
   int pops = 0, gap_pops = 0, cs_viol = 0, full_viol = 0;
   int full_cycles = 0, rd_timing_err = 0, pop_idx = 0, cs_low = 0;
   logic err_csn = 1'b0, exp_rdv = 1'b0;
   logic prev_csn = 1'b1, prev_ready = 1'b0;
   logic [7:0] exp_rdd = 8'h00;

   // SPI slave plus FIFOs: each pushed byte returns one RX byte a cycle later.
   always @(posedge clk) begin : fifo_model
      logic p, r;
      logic [7:0] d;
      p = tx_write;
      r = rx_read;
      d = tx_data;
      #1;
      if (r && rxq.size() > 0) void'(rxq.pop_front());
      if (full_cnt > 0) full_cnt--;
      if (p) begin
         if (miso.size() > 0) rxq.push_back(miso.pop_front());
         else rxq.push_back(d);
         pushes++;
         if (bp_en && pushes == 2) full_cnt = 5;
      end
      tx_full  = full_cnt > 0;
      rx_empty = rx_hold || rxq.size() == 0;
      rx_data  = rxq.size() > 0 ? rxq[0] : 8'h00;
   end

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         pop_idx = 0;
         exp_rdv = 1'b0;
         prev_csn = 1'b1;
         prev_ready = 1'b0;
      end else begin
         if (tx_write) begin
            tx_log.push_back(tx_data);
            if (cs_n) cs_viol++;
            if (tx_full) full_viol++;
            if (first_tx < 0) first_tx = cyc;
         end
         if (tx_full) full_cycles++;
         if (!cs_n) cs_low++;
         if (rx_read) begin
            if (cs_n) gap_pops++;
            else pops++;
         end
         if (bus.rd_valid !== exp_rdv ||
             (exp_rdv && bus.rd_data !== exp_rdd) ||
             (bus.rd_last && !bus.rd_valid))
            rd_timing_err++;
         if (bus.rd_valid) rd_log.push_back({bus.rd_last, bus.rd_data});
         exp_rdv = rx_read && !cs_n && !cur_write && pop_idx >= 2;
         exp_rdd = rx_data;
         pop_idx = cs_n ? 0 : pop_idx + (rx_read ? 1 : 0);
         if (bus.done) begin done_cnt++; done_cyc = cyc; end
         if (bus.err) begin err_cnt++; err_cyc = cyc; err_csn = cs_n; end
         if (!cs_n && prev_csn) csfall_cyc = cyc;
         if (bus.req_ready && !prev_ready) rdy_rise_cyc = cyc;
         prev_csn = cs_n;
         prev_ready = bus.req_ready;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_logs();
      tx_log.delete(); rd_log.delete(); miso.delete();
      pushes = 0; first_tx = -1; done_cnt = 0; err_cnt = 0;
      done_cyc = -1; err_cyc = -1; csfall_cyc = -1; rdy_rise_cyc = -1;
      pops = 0; gap_pops = 0; cs_viol = 0; full_viol = 0;
      full_cycles = 0; rd_timing_err = 0; cs_low = 0;
   endtask

   task automatic wait_ready();
      int k = 0;
      while (bus.req_ready !== 1'b1 && k < 3000) begin tick(); k++; end
      n_checks++;
      if (bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_wait: req_ready=%b required 1", bus.req_ready);
      end
   endtask

   task automatic start_req(input bit w, input logic [7:0] a,
                            input logic [7:0] d, input logic [2:0] l);
      wait_ready();
      cur_write = w;
      bus.req_write = w;
      bus.req_addr = a;
      bus.req_wdata = d;
      bus.req_len = l;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_end();
      int k = 0;
      while (done_cnt + err_cnt == 0 && k < 3000) begin tick(); k++; end
      n_checks++;
      if (done_cnt + err_cnt == 0) begin
         n_fail++;
         $display("FAIL end_wait: no done/err after %0d cycles", k);
      end
   endtask

   task automatic check_tx(input string nm, input logic [7:0] e[$]);
      n_checks++;
      if (tx_log.size() != e.size()) begin
         n_fail++;
         $display("FAIL %s_txlen: got %0d required %0d", nm, tx_log.size(), e.size());
      end
      for (int i = 0; i < e.size() && i < tx_log.size(); i++) begin
         n_checks++;
         if (tx_log[i] !== e[i]) begin
            n_fail++;
            $display("FAIL %s_tx[%0d]: got %h required %h", nm, i, tx_log[i], e[i]);
         end
      end
   endtask

   task automatic check_rd(input string nm, input logic [8:0] e[$]);
      n_checks++;
      if (rd_log.size() != e.size()) begin
         n_fail++;
         $display("FAIL %s_rdlen: got %0d required %0d", nm, rd_log.size(), e.size());
      end
      for (int i = 0; i < e.size() && i < rd_log.size(); i++) begin
         n_checks++;
         if (rd_log[i] !== e[i]) begin
            n_fail++;
            $display("FAIL %s_rd[%0d]: got {last,data}=%h required %h", nm, i, rd_log[i], e[i]);
         end
      end
      n_checks++;
      if (rd_timing_err !== 0) begin
         n_fail++;
         $display("FAIL %s_rd_timing: got %0d bad cycles required 0", nm, rd_timing_err);
      end
   endtask

   task automatic test_reset();
      repeat (3) tick();
      n_checks++;
      if ({cs_n, bus.req_ready, tx_write, rx_read, bus.rd_valid,
           bus.rd_last, bus.done, bus.err} !== 8'b1000_0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b required 10000000",
                  {cs_n, bus.req_ready, tx_write, rx_read, bus.rd_valid,
                   bus.rd_last, bus.done, bus.err});
      end
      n_checks++;
      if ({tx_data, bus.rd_data} !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_data: got %h required 0000", {tx_data, bus.rd_data});
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus.req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL release_ready: got %b required 0", bus.req_ready);
      end
      tick();
      n_checks++;
      if (bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL post_release_ready: got %b required 1", bus.req_ready);
      end
   endtask

   task automatic test_write();
      clear_logs();
      start_req(1'b1, 8'h2D, 8'h02, 3'd0);
      wait_end();
      wait_ready();
      check_tx("wr", '{8'h0A, 8'h2D, 8'h02});
      check_rd("wr", '{});
      n_checks++;
      if (pops !== 3 || done_cnt !== 1 || err_cnt !== 0) begin
         n_fail++;
         $display("FAIL wr_counts: pops/done/err got %0d/%0d/%0d required 3/1/0",
                  pops, done_cnt, err_cnt);
      end
      n_checks++;
      if (cs_low !== CS_SETUP + 5 || cs_viol !== 0 || gap_pops !== 0) begin
         n_fail++;
         $display("FAIL wr_cs: cs_low/viol/gap_pops got %0d/%0d/%0d required %0d/0/0",
                  cs_low, cs_viol, gap_pops, CS_SETUP + 5);
      end
   endtask

   task automatic test_read_single();
      clear_logs();
      miso = '{8'hFF, 8'hFF, 8'hAD};
      start_req(1'b0, 8'h00, 8'h00, 3'd0);
      wait_end();
      wait_ready();
      check_tx("rd1", '{8'h0B, 8'h00, 8'h00});
      check_rd("rd1", '{9'h1AD});
      n_checks++;
      if (done_cnt !== 1) begin
         n_fail++;
         $display("FAIL rd1_done: got %0d required 1", done_cnt);
      end
   endtask

   task automatic test_read_burst();
      clear_logs();
      miso = '{8'hA0, 8'hA1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      start_req(1'b0, 8'h0E, 8'h00, 3'd5);
      wait_end();
      wait_ready();
      check_tx("rd6", '{8'h0B, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      check_rd("rd6", '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h166});
      n_checks++;
      if (pops !== 8 || done_cnt !== 1) begin
         n_fail++;
         $display("FAIL rd6_counts: pops/done got %0d/%0d required 8/1", pops, done_cnt);
      end
   endtask

   task automatic test_backpressure();
      clear_logs();
      bp_en = 1;
      miso = '{8'h90, 8'h91, 8'hC1, 8'hC2, 8'hC3};
      start_req(1'b0, 8'h33, 8'h00, 3'd2);
      wait_end();
      wait_ready();
      bp_en = 0;
      check_tx("bp", '{8'h0B, 8'h33, 8'h00, 8'h00, 8'h00});
      check_rd("bp", '{9'h0C1, 9'h0C2, 9'h1C3});
      n_checks++;
      if (full_cycles !== 5 || full_viol !== 0) begin
         n_fail++;
         $display("FAIL bp_full: full_cycles/push_while_full got %0d/%0d required 5/0",
                  full_cycles, full_viol);
      end
   endtask

   task automatic test_timeout();
      clear_logs();
      rx_hold = 1;
      start_req(1'b1, 8'h5A, 8'hC3, 3'd0);
      wait_end();
      rx_hold = 0;
      wait_ready();
      n_checks++;
      if (err_cyc - first_tx !== TIMEOUT) begin
         n_fail++;
         $display("FAIL to_latency: got %0d required %0d", err_cyc - first_tx, TIMEOUT);
      end
      n_checks++;
      if (err_cnt !== 1 || done_cnt !== 0 || err_csn !== 1'b1) begin
         n_fail++;
         $display("FAIL to_pulse: err/done/cs_n got %0d/%0d/%b required 1/0/1",
                  err_cnt, done_cnt, err_csn);
      end
      n_checks++;
      if (rdy_rise_cyc - err_cyc !== CS_GAP + 1) begin
         n_fail++;
         $display("FAIL to_ready: got %0d required %0d", rdy_rise_cyc - err_cyc, CS_GAP + 1);
      end
      n_checks++;
      if (gap_pops !== 3 || rxq.size() !== 0 || rd_log.size() !== 0) begin
         n_fail++;
         $display("FAIL to_flush: gap_pops/left/rd got %0d/%0d/%0d required 3/0/0",
                  gap_pops, rxq.size(), rd_log.size());
      end
   endtask

   task automatic test_back_to_back();
      int k = 0;
      clear_logs();
      wait_ready();
      cur_write = 1;
      bus.req_write = 1'b1;
      bus.req_addr = 8'h40;
      bus.req_wdata = 8'h55;
      bus.req_valid = 1'b1;
      tick();
      bus.req_addr = 8'h41;
      bus.req_wdata = 8'h66;
      while (done_cnt < 1 && k < 3000) begin tick(); k++; end
      while (csfall_cyc <= done_cyc && k < 3000) begin tick(); k++; end
      bus.req_valid = 1'b0;
      n_checks++;
      if (csfall_cyc - done_cyc !== CS_GAP + 2) begin
         n_fail++;
         $display("FAIL b2b_accept: got %0d required %0d", csfall_cyc - done_cyc, CS_GAP + 2);
      end
      while (done_cnt < 2 && k < 3000) begin tick(); k++; end
      wait_ready();
      check_tx("b2b", '{8'h0A, 8'h40, 8'h55, 8'h0A, 8'h41, 8'h66});
      n_checks++;
      if (done_cnt !== 2) begin
         n_fail++;
         $display("FAIL b2b_done: got %0d required 2", done_cnt);
      end
   endtask

   task automatic test_reset_mid_xfer();
      int k = 0;
      clear_logs();
      miso = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
      start_req(1'b0, 8'h0E, 8'h00, 3'd7);
      while (tx_log.size() < 4 && k < 3000) begin tick(); k++; end
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if ({cs_n, bus.req_ready, tx_write, rx_read, bus.rd_valid,
           bus.rd_last, bus.done, bus.err} !== 8'b1000_0000) begin
         n_fail++;
         $display("FAIL async_rst_ctrl: got %b required 10000000",
                  {cs_n, bus.req_ready, tx_write, rx_read, bus.rd_valid,
                   bus.rd_last, bus.done, bus.err});
      end
      n_checks++;
      if ({tx_data, bus.rd_data} !== 16'h0000) begin
         n_fail++;
         $display("FAIL async_rst_data: got %h required 0000", {tx_data, bus.rd_data});
      end
      tick();
      rxq.delete();
      tick();
      clear_logs();
      rst = 1'b1;
      start_req(1'b1, 8'h7F, 8'hA5, 3'd0);
      wait_end();
      wait_ready();
      check_tx("rst_wr", '{8'h0A, 8'h7F, 8'hA5});
      n_checks++;
      if (done_cnt !== 1 || pops !== 3 || rd_log.size() !== 0) begin
         n_fail++;
         $display("FAIL rst_wr_counts: done/pops/rd got %0d/%0d/%0d required 1/3/0",
                  done_cnt, pops, rd_log.size());
      end
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr = 8'h00;
      bus.req_wdata = 8'h00;
      bus.req_len = 3'd0;
      test_reset();
      test_write();
      test_read_single();
      test_read_burst();
      test_backpressure();
      test_timeout();
      test_back_to_back();
      test_reset_mid_xfer();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_sequencer.md
SPI_SEQUENCER -- requirements
Module: spi_sequencer

Parameters
REQ-001 The block SHALL have parameter CS_SETUP, default 2: number of cycles cs_n is held low before the first TX push.
REQ-002 The block SHALL have parameter CS_GAP, default 4: minimum number of cycles cs_n is held high after a transaction.
REQ-003 The block SHALL have parameter TIMEOUT, default 1023: maximum number of cycles without an RX pop before the transaction is aborted.

Interface
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-006 req_valid  in  1  transaction request.
REQ-007 req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
REQ-008 req_write  in  1  1 = register write, 0 = register read.
REQ-009 req_addr  in  8  register address.
REQ-010 req_wdata  in  8  write data byte.
REQ-011 req_len  in  3  read burst length minus 1 (1..8 bytes); ignored for writes.
REQ-012 tx_write  out  1  TX FIFO push.
REQ-013 tx_data  out  8  TX FIFO byte.
REQ-014 tx_full  in  1  TX FIFO full.
REQ-015 rx_read  out  1  RX FIFO pop; the RX FIFO is first-word-fall-through, so rx_data is valid whenever !rx_empty.
REQ-016 rx_data  in  8  RX FIFO head byte.
REQ-017 rx_empty  in  1  RX FIFO empty.
REQ-018 cs_n  out  1  SPI chip select, active-low.
REQ-019 rd_data, rd_valid, rd_last  out  8/1/1  read byte, one-cycle strobe, and last-byte flag.
REQ-020 done, err  out  1/1  one-cycle pulses marking normal completion and timeout abort.

Function
REQ-021 Requests SHALL be latched on acceptance; the byte count N SHALL be 3 for a write and req_len+3 for a read.
REQ-022 The TX byte order SHALL be: command (0x0A write, 0x0B read), address, then either req_wdata (write) or req_len+1 bytes of 0x00 (read).
REQ-023 The FSM SHALL have states IDLE, SETUP, XFER, GAP and ABORT.
- IDLE -> SETUP on accept.
- SETUP -> XFER after CS_SETUP cycles.
- XFER -> GAP when rx_cnt reaches N.
- XFER -> ABORT on timeout.
- ABORT -> GAP.
- GAP -> IDLE after CS_GAP cycles.
REQ-024 cs_n SHALL be 0 exactly in SETUP and XFER and 1 in all other states.
REQ-025 In XFER, tx_write SHALL be asserted in each cycle where tx_cnt<N and !tx_full; tx_cnt SHALL increment per push; no byte SHALL be skipped or repeated under backpressure.
REQ-026 In XFER, rx_read SHALL be asserted in each cycle where rx_cnt<N and !rx_empty, independent of and concurrent with TX pushes.
REQ-027 For a read, the RX bytes at index 0 and 1 SHALL be discarded; each later popped byte SHALL appear on rd_data with rd_valid=1 exactly one cycle after its pop.
REQ-028 rd_last SHALL be 1 together with rd_valid for the final read byte only; a write SHALL produce no rd_valid.
REQ-029 done SHALL pulse for one cycle on the XFER->GAP transition.
REQ-030 A 16-bit idle counter SHALL clear on every RX pop and on entry to XFER, and SHALL increment otherwise in XFER; reaching TIMEOUT SHALL cause the transition to ABORT.
REQ-031 ABORT SHALL last one cycle and pulse err; done SHALL NOT pulse for an aborted transaction, and no rd_valid SHALL follow the abort.
REQ-032 In GAP following ABORT, rx_read SHALL be asserted whenever !rx_empty so that stale bytes are flushed; in GAP following normal completion, rx_read SHALL be 0.
REQ-033 req_valid SHALL be ignored outside IDLE; a request held through GAP SHALL be accepted on the first IDLE cycle.

Reset
REQ-034 While rst=0, all of the following SHALL hold:
- state = IDLE;
- cs_n = 1;
- tx_write = rx_read = rd_valid = rd_last = done = err = 0;
- tx_data = rd_data = 0x00;
- all counters = 0;
- req_ready = 0.
REQ-035 Reset assertion SHALL take effect asynchronously even mid-XFER; the first accept after reset release SHALL be possible no earlier than the cycle after release.

Verification
REQ-036 Write addr 0x2D data 0x02 with an echoing RX model -> TX bytes 0x0A, 0x2D, 0x02; 3 RX pops; cs_n low throughout; one done pulse; no rd_valid.
REQ-037 Read addr 0x00 with req_len=0 and RX bytes 0xFF, 0xFF, 0xAD -> a single rd_valid with rd_data=0xAD and rd_last=1.
REQ-038 Read addr 0x0E with req_len=5 -> 8 TX bytes (0x0B, 0x0E, six 0x00); 6 rd_valid strobes in order; rd_last only on the 6th.
REQ-039 tx_full held high for 5 cycles after the 2nd push -> no tx_write during those cycles; the byte sequence is unchanged.
REQ-040 rx_empty held high throughout XFER -> err pulse exactly TIMEOUT cycles after XFER entry; cs_n returns to 1; req_ready=1 after CS_GAP cycles.
REQ-041 rst driven 0 mid-XFER of a burst read -> cs_n=1 and all strobes 0 without a clock edge; a new write then completes normally.
